// File: rtl/pak_arb_pkg.sv
// Shared definitions for the packet stream arbiter.
// Holds the arbiter state encoding and the default sizing constants
// (source count, beat width, maximum forwarded packet length).
package pak_arb_pkg;

  localparam int unsigned DEF_NUM_SRC    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAX_LEN    = 382;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pak_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        - per-source request vector
//   last_grant - most recently completed grant; search starts one above it
//   winner     - first requesting source found, wrapping modulo NUM_SRC
//   any        - at least one request is present
module pak_rr_pick
  import pak_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
  localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W-1:0] idx;
  logic            found;

  // Walk last_grant+1 .. last_grant+NUM_SRC; the first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = ID_W'((32'(last_grant) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/pak_stream_arbiter.sv
// Round-robin arbiter merging NUM_SRC packet streams into one packetizer input.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   src_data/valid/last/ready - per-source beat streams (source i at [i*DATA_WIDTH +: DATA_WIDTH])
//   m_data/valid/last, m_ready - merged stream toward the packetizer
//   pak_overflow              - blocks new grants while high
//   grant_id                  - currently granted source
//   busy                      - packet in progress (XFER or DRAIN)
//   trunc_err                 - one-cycle pulse after a forced truncation
//   pkt_done                  - one-cycle pulse after a packet ends on the m_ side
module pak_stream_arbiter
  import pak_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC    = DEF_NUM_SRC,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned MAX_LEN    = DEF_MAX_LEN,
  localparam int unsigned ID_W       = $clog2(NUM_SRC)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  input  logic                          pak_overflow,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          trunc_err,
  output logic                          pkt_done
);

  localparam int unsigned      CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             trunc_err_q, trunc_err_d;
  logic             pkt_done_q, pkt_done_d;

  logic [ID_W-1:0]       rr_winner;
  logic                  rr_any;
  logic [DATA_WIDTH-1:0] src_word [NUM_SRC];
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  at_max;

  pak_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req        (src_valid),
    .last_grant (last_grant_q),
    .winner     (rr_winner),
    .any        (rr_any)
  );

  // Split the flat source bus into per-source words for the grant mux.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_split
    assign src_word[g] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign sel_data  = src_word[grant_id_q];
  assign sel_valid = src_valid[grant_id_q];
  assign sel_last  = src_last[grant_id_q];
  assign at_max    = (beat_cnt_q == LAST_IDX);

  // Next-state and stream steering.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    trunc_err_d  = 1'b0;
    pkt_done_d   = 1'b0;
    src_ready    = '0;
    m_data       = '0;
    m_valid      = 1'b0;
    m_last       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Overflow only holds off new grants; the bubble cycle is spent here.
        if (rr_any && !pak_overflow) begin
          grant_id_d = rr_winner;
          beat_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end

      ST_XFER: begin
        m_data                = sel_data;
        m_valid               = sel_valid;
        m_last                = sel_valid && (sel_last || at_max);
        src_ready[grant_id_q] = m_ready;
        if (sel_valid && m_ready) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (sel_last) begin
            pkt_done_d   = 1'b1;
            last_grant_d = grant_id_q;
            state_d      = ST_IDLE;
          end else if (at_max) begin
            // Length cap reached: close the packet downstream, drop the rest.
            trunc_err_d = 1'b1;
            pkt_done_d  = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        src_ready[grant_id_q] = 1'b1;
        if (sel_valid && sel_last) begin
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      trunc_err_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      trunc_err_q  <= trunc_err_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign grant_id  = grant_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign trunc_err = trunc_err_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_pak_stream_arbiter.sv
// Scoreboard bench for pak_stream_arbiter (NUM_SRC=4, DATA_WIDTH=32, MAX_LEN=382).
module tb_pak_stream_arbiter;

  localparam int unsigned NSRC = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXL = 382;
  localparam int unsigned IDW  = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [DW-1:0]        sd [NSRC];
  logic [NSRC*DW-1:0]   src_data;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_last;
  logic [NSRC-1:0]      src_ready;
  logic [DW-1:0]        m_data;
  logic                 m_valid;
  logic                 m_last;
  logic                 m_ready;
  logic                 pak_overflow;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 trunc_err;
  logic                 pkt_done;

  assign src_data = {sd[3], sd[2], sd[1], sd[0]};

  always #5 clock = ~clock;

  pak_stream_arbiter #(
    .NUM_SRC    (NSRC),
    .DATA_WIDTH (DW),
    .MAX_LEN    (MAXL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .pak_overflow (pak_overflow),
    .grant_id     (grant_id),
    .busy         (busy),
    .trunc_err    (trunc_err),
    .pkt_done     (pkt_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-source pending beats {last, data} and expected m_ side beats {id, last, data}.
  logic [DW:0]      srcq [NSRC][$];
  logic [IDW+DW:0]  exp_q [$];

  int n_beats, n_done, n_trunc, n_drained, n_gap, n_mirror_bad;
  bit toggle_ready;

  function automatic logic [DW-1:0] mk_data(input int s, input int p, input int b);
    return {8'(s), 8'(p), 16'(b)};
  endfunction

  function automatic bit pending();
    logic [IDW-1:0] ix;
    for (int i = 0; i < int'(NSRC); i++) begin
      ix = IDW'(i);
      if (srcq[ix].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic load_pkt(input int s, input int p, input int len);
    logic [IDW-1:0] ix;
    ix = IDW'(s);
    for (int b = 0; b < len; b++) srcq[ix].push_back({(b == len - 1), mk_data(s, p, b)});
  endtask

  // fwd beats are expected downstream; the last of them carries m_last.
  task automatic expect_pkt(input int s, input int p, input int fwd);
    for (int b = 0; b < fwd; b++) exp_q.push_back({IDW'(s), (b == fwd - 1), mk_data(s, p, b)});
  endtask

  task automatic drive_src();
    logic [IDW-1:0] ix;
    for (int i = 0; i < int'(NSRC); i++) begin
      ix = IDW'(i);
      if (srcq[ix].size() > 0) begin
        src_valid[ix] = 1'b1;
        sd[ix]        = srcq[ix][0][DW-1:0];
        src_last[ix]  = srcq[ix][0][DW];
      end else begin
        src_valid[ix] = 1'b0;
        sd[ix]        = '0;
        src_last[ix]  = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    logic [IDW-1:0] ix;
    for (int i = 0; i < int'(NSRC); i++) begin
      ix = IDW'(i);
      srcq[ix].delete();
    end
    exp_q.delete();
    drive_src();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    pak_overflow = 1'b0;
    m_ready      = 1'b1;
    toggle_ready = 1'b0;
    clear_all();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Runs traffic until sources, scoreboard and DUT are all quiet.
  task automatic run_traffic(input int budget);
    int              cyc;
    bit              started;
    logic [NSRC-1:0] acc;
    logic [IDW+DW:0] e;
    logic [IDW-1:0]  ix;
    n_beats = 0; n_done = 0; n_trunc = 0; n_drained = 0; n_gap = 0; n_mirror_bad = 0;
    cyc = 0; started = 1'b0;
    drive_src();
    while ((busy || exp_q.size() != 0 || pending()) && cyc < budget) begin
      @(negedge clock);
      if (m_valid && m_ready) begin
        n_beats++;
        started = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_extra: got id %0d last %0b data %h, required no beat", grant_id, m_last, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant_id, m_last, m_data} !== e) begin
            n_fail++;
            $display("FAIL beat_data: got id %0d last %0b data %h, required id %0d last %0b data %h",
                     grant_id, m_last, m_data, e[IDW+DW:DW+1], e[DW], e[DW-1:0]);
          end
        end
      end else if (started && !m_valid && exp_q.size() != 0) begin
        n_gap++;
      end
      if (m_valid && (src_ready !== (NSRC'(m_ready) << grant_id))) n_mirror_bad++;
      if (pkt_done) n_done++;
      if (trunc_err) n_trunc++;
      acc = src_valid & src_ready;
      if (!m_valid) n_drained += $countones(acc);
      @(posedge clock);
      #1;
      for (int i = 0; i < int'(NSRC); i++) begin
        ix = IDW'(i);
        if (acc[ix]) void'(srcq[ix].pop_front());
      end
      drive_src();
      if (toggle_ready) m_ready = ~m_ready;
      cyc++;
    end
    n_checks++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL traffic_timeout: ran %0d cycles, required completion within %0d", cyc, budget);
    end
    repeat (2) begin
      @(negedge clock);
      if (pkt_done) n_done++;
      if (trunc_err) n_trunc++;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    pak_overflow = 1'b0;
    m_ready      = 1'b1;
    toggle_ready = 1'b0;
    clear_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (src_ready !== 4'b0) begin n_fail++; $display("FAIL rst_src_ready: got %b, required 0000", src_ready); end
    n_checks++; if (m_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
    n_checks++; if (m_last !== 1'b0)    begin n_fail++; $display("FAIL rst_m_last: got %b, required 0", m_last); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++; if (trunc_err !== 1'b0) begin n_fail++; $display("FAIL rst_trunc_err: got %b, required 0", trunc_err); end
    n_checks++; if (pkt_done !== 1'b0)  begin n_fail++; $display("FAIL rst_pkt_done: got %b, required 0", pkt_done); end
    n_checks++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_two_sources();
    do_reset();
    load_pkt(0, 1, 5);
    load_pkt(2, 1, 5);
    expect_pkt(0, 1, 5);
    expect_pkt(2, 1, 5);
    run_traffic(200);
    n_checks++; if (n_beats != 10) begin n_fail++; $display("FAIL two_src_beats: got %0d, required 10", n_beats); end
    n_checks++; if (n_done != 2)   begin n_fail++; $display("FAIL two_src_pkt_done: got %0d, required 2", n_done); end
    n_checks++; if (n_gap != 1)    begin n_fail++; $display("FAIL two_src_gap: got %0d, required 1", n_gap); end
    n_checks++; if (n_trunc != 0)  begin n_fail++; $display("FAIL two_src_trunc: got %0d, required 0", n_trunc); end
  endtask

  task automatic test_round_robin();
    do_reset();
    load_pkt(0, 1, 3);
    load_pkt(1, 1, 3);
    load_pkt(2, 1, 3);
    load_pkt(3, 1, 3);
    load_pkt(0, 2, 3);
    expect_pkt(0, 1, 3);
    expect_pkt(1, 1, 3);
    expect_pkt(2, 1, 3);
    expect_pkt(3, 1, 3);
    expect_pkt(0, 2, 3);
    run_traffic(300);
    n_checks++; if (n_beats != 15) begin n_fail++; $display("FAIL rr_beats: got %0d, required 15", n_beats); end
    n_checks++; if (n_done != 5)   begin n_fail++; $display("FAIL rr_pkt_done: got %0d, required 5", n_done); end
    n_checks++; if (n_gap != 4)    begin n_fail++; $display("FAIL rr_gap: got %0d, required 4", n_gap); end
  endtask

  task automatic test_truncation();
    do_reset();
    load_pkt(1, 1, 400);
    expect_pkt(1, 1, int'(MAXL));
    run_traffic(1000);
    n_checks++; if (n_beats != 382) begin n_fail++; $display("FAIL trunc_beats: got %0d, required 382", n_beats); end
    n_checks++; if (n_trunc != 1)   begin n_fail++; $display("FAIL trunc_pulses: got %0d, required 1", n_trunc); end
    n_checks++; if (n_done != 1)    begin n_fail++; $display("FAIL trunc_pkt_done: got %0d, required 1", n_done); end
    n_checks++; if (n_drained != 18) begin n_fail++; $display("FAIL trunc_drained: got %0d, required 18", n_drained); end
  endtask

  task automatic test_exact_max();
    do_reset();
    load_pkt(2, 1, int'(MAXL));
    expect_pkt(2, 1, int'(MAXL));
    run_traffic(1000);
    n_checks++; if (n_beats != 382) begin n_fail++; $display("FAIL exact_beats: got %0d, required 382", n_beats); end
    n_checks++; if (n_trunc != 0)   begin n_fail++; $display("FAIL exact_trunc: got %0d, required 0", n_trunc); end
    n_checks++; if (n_done != 1)    begin n_fail++; $display("FAIL exact_pkt_done: got %0d, required 1", n_done); end
    n_checks++; if (n_drained != 0) begin n_fail++; $display("FAIL exact_drained: got %0d, required 0", n_drained); end
  endtask

  task automatic test_overflow();
    int n_bad;
    do_reset();
    pak_overflow = 1'b1;
    m_ready      = 1'b0;
    load_pkt(3, 1, 2);
    drive_src();
    n_bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (busy !== 1'b0 || src_ready !== 4'b0) n_bad++;
    end
    n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL ovf_no_grant: got %0d granted cycles, required 0", n_bad); end
    @(posedge clock);
    #1 pak_overflow = 1'b0;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_early_grant: got busy %b, required 0", busy); end
    @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL ovf_grant_busy: got %b, required 1", busy); end
    n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL ovf_grant_id: got %0d, required 3", grant_id); end
    @(posedge clock);
    #1 m_ready = 1'b1;
    expect_pkt(3, 1, 2);
    run_traffic(50);
    n_checks++; if (n_beats != 2) begin n_fail++; $display("FAIL ovf_beats: got %0d, required 2", n_beats); end
    n_checks++; if (n_done != 1)  begin n_fail++; $display("FAIL ovf_pkt_done: got %0d, required 1", n_done); end
  endtask

  task automatic test_backpressure();
    do_reset();
    toggle_ready = 1'b1;
    load_pkt(0, 1, 10);
    expect_pkt(0, 1, 10);
    run_traffic(100);
    toggle_ready = 1'b0;
    m_ready      = 1'b1;
    n_checks++; if (n_beats != 10)     begin n_fail++; $display("FAIL bp_beats: got %0d, required 10", n_beats); end
    n_checks++; if (n_mirror_bad != 0) begin n_fail++; $display("FAIL bp_ready_mirror: got %0d bad cycles, required 0", n_mirror_bad); end
    n_checks++; if (n_done != 1)       begin n_fail++; $display("FAIL bp_pkt_done: got %0d, required 1", n_done); end
  endtask

  task automatic test_reset_mid_packet();
    int              beats;
    int              cyc;
    logic [NSRC-1:0] acc;
    logic [IDW-1:0]  ix;
    do_reset();
    // Complete one packet on source 1 so the round-robin pointer moves off its reset value.
    load_pkt(1, 1, 2);
    expect_pkt(1, 1, 2);
    run_traffic(50);
    load_pkt(2, 1, 8);
    drive_src();
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 50) begin
      @(negedge clock);
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== mk_data(2, 1, beats)) begin
          n_fail++;
          $display("FAIL mid_beat_data: got %h, required %h", m_data, mk_data(2, 1, beats));
        end
        beats++;
      end
      acc = src_valid & src_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < int'(NSRC); i++) begin
        ix = IDW'(i);
        if (acc[ix]) void'(srcq[ix].pop_front());
      end
      drive_src();
      cyc++;
    end
    n_checks++; if (beats != 4) begin n_fail++; $display("FAIL mid_timeout: got %0d beats, required 4", beats); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++; if (m_valid !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_m_valid: got %b, required 0", m_valid); end
    n_checks++; if (m_last !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_m_last: got %b, required 0", m_last); end
    n_checks++; if (src_ready !== 4'b0) begin n_fail++; $display("FAIL mid_rst_src_ready: got %b, required 0000", src_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    n_checks++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL mid_rst_grant_id: got %0d, required 0", grant_id); end
    n_checks++; if (pkt_done !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_pkt_done: got %b, required 0", pkt_done); end
    n_checks++; if (trunc_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_trunc_err: got %b, required 0", trunc_err); end
    clear_all();
    @(posedge clock);
    #1 reset = 1'b0;
    // Source 0 must win over source 2 after reset.
    load_pkt(2, 2, 2);
    load_pkt(0, 2, 2);
    expect_pkt(0, 2, 2);
    expect_pkt(2, 2, 2);
    run_traffic(50);
    n_checks++; if (n_beats != 4) begin n_fail++; $display("FAIL mid_after_beats: got %0d, required 4", n_beats); end
    n_checks++; if (n_done != 2)  begin n_fail++; $display("FAIL mid_after_pkt_done: got %0d, required 2", n_done); end
  endtask

  initial begin
    test_reset();
    test_two_sources();
    test_round_robin();
    test_truncation();
    test_exact_max();
    test_overflow();
    test_backpressure();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pak_stream_arbiter.md
PAK_STREAM_ARBITER -- requirements
Module: pak_stream_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of upstream packet sources (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, beat width; equals the packetizer IN_WIDTH.
REQ-003 Parameter MAX_LEN, default 382, maximum beats per packet forwarded.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 src_data  in  NUM_SRC*DATA_WIDTH  source beats; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 src_valid  in  NUM_SRC  per-source beat valid.
REQ-009 src_last  in  NUM_SRC  per-source end-of-packet flag.
REQ-010 src_ready  out  NUM_SRC  per-source beat accept.
REQ-011 m_data  out  DATA_WIDTH  beat to the packetizer dataIn.
REQ-012 m_valid  out  1  beat valid to the packetizer validIn.
REQ-013 m_last  out  1  end-of-packet to the packetizer lastIn.
REQ-014 m_ready  in  1  downstream accept; tie high when the packetizer has no backpressure.
REQ-015 pak_overflow  in  1  packetizer overflow status.
REQ-016 grant_id  out  $clog2(NUM_SRC)  currently granted source.
REQ-017 busy  out  1  high while in XFER or DRAIN.
REQ-018 trunc_err  out  1  one-cycle pulse on each forced truncation.
REQ-019 pkt_done  out  1  one-cycle pulse when a packet completes on the m_ interface.

Function
REQ-020 A beat SHALL transfer on a port when valid and ready are both high at a rising clock edge.
REQ-021 States: IDLE, XFER, DRAIN.
REQ-022 IDLE: all src_ready low, m_valid low; if any src_valid is high and pak_overflow is low, latch the round-robin winner into grant_id and enter XFER next cycle. Arbitration costs 1 bubble cycle.
REQ-023 Round-robin: search starts at last_grant+1 modulo NUM_SRC; the first source with src_valid high wins.
REQ-024 XFER: m_data, m_valid and m_last SHALL be combinationally driven from source grant_id; src_ready[grant_id] = m_ready; all other src_ready low.
REQ-025 beat_cnt (width $clog2(MAX_LEN+1)) SHALL clear on entry to XFER and increment on each m_ transfer.
REQ-026 An XFER transfer with src_last high SHALL pulse pkt_done, set last_grant = grant_id, and return to IDLE.
REQ-027 If the transfer at beat_cnt == MAX_LEN-1 carries no src_last, m_last SHALL be forced high on that beat; trunc_err and pkt_done SHALL pulse; the state SHALL go to DRAIN.
REQ-028 DRAIN: m_valid low; src_ready[grant_id] high; beats are discarded until a src_last transfer, then set last_grant and go to IDLE.
REQ-029 pak_overflow SHALL gate only new grants; a packet already in XFER completes.
REQ-030 src_valid deasserting mid-packet SHALL hold XFER; no timeout.
REQ-031 A packet of exactly MAX_LEN beats with src_last on the final beat SHALL complete normally, without trunc_err.

Reset
REQ-032 On reset: state IDLE, last_grant = NUM_SRC-1 (source 0 has first priority), grant_id 0, beat_cnt 0.
REQ-033 On reset: src_ready, m_valid, m_last, busy, trunc_err and pkt_done SHALL be 0.
REQ-034 Reset mid-packet SHALL abandon the packet immediately; no m_last is emitted.

Structure
REQ-035 Package pak_arb_pkg SHALL hold the state enum and the default NUM_SRC, DATA_WIDTH and MAX_LEN constants.
REQ-036 Submodule pak_rr_pick SHALL hold the combinational round-robin picker: inputs req and last_grant; outputs winner and any.

Verification
REQ-037 Sources 0 and 2 each hold one 5-beat packet, m_ready=1 -> source 0 then source 2 are forwarded; pkt_done pulses twice; 1 idle cycle separates the packets.
REQ-038 All 4 sources request continuously with 3-beat packets -> grant order 0,1,2,3,0.
REQ-039 Source 1 sends a 400-beat packet with MAX_LEN=382 -> 382 beats are forwarded with m_last on beat 382; trunc_err pulses once; 18 beats are drained; m_valid stays low while draining.
REQ-040 pak_overflow is high while source 3 requests -> no grant; grant occurs 1 cycle after pak_overflow falls.
REQ-041 m_ready toggles every cycle during a 10-beat packet -> exactly 10 beats are forwarded, in order, and src_ready mirrors m_ready.
REQ-042 Reset asserted at beat 4 of 8 -> the next cycle shows all outputs at 0, state IDLE, and source 0 has first priority.
